// File: rtl/operand_bank.sv
`default_nettype none
// ============================================================================
//  Module   : operand_bank
//  Purpose  : Small register bank driven by a three-state command sequencer.
//             A command (READ, WRITE, SWAP, CLEAR) is captured in IDLE,
//             executed on the following edge, and acknowledged by a
//             one-cycle ready pulse. Output1/Output2 always present the
//             post-command contents of reg[sel_a]/reg[sel_b].
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             en, mode            - command strobe and code (00 RD, 01 WR,
//                                   10 SWAP, 11 CLEAR)
//             sel_a, sel_b        - register indices for ports 1 and 2
//             value1, value2      - write data for reg[sel_a] / reg[sel_b]
//             Output1, Output2    - registered post-command contents
//             ready               - one-cycle completion pulse (registered)
//             busy                - high while a command is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module operand_bank #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SEL_W = 2   // must equal log2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2,
    output logic             ready,
    output logic             busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_MODE_READ  = 2'b00;
    localparam logic [1:0] c_MODE_WRITE = 2'b01;
    localparam logic [1:0] c_MODE_SWAP  = 2'b10;
    localparam logic [1:0] c_MODE_CLEAR = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic [WIDTH-1:0] r_val1;
    logic [WIDTH-1:0] r_val2;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_out1;
    logic [WIDTH-1:0] r_out2;
    logic             r_ready;

    // Bank contents as they will look after the latched command executes.
    // Both outputs are taken from this view so they reflect post-command
    // state, including the aliasing cases (sel_a == sel_b).
    logic [WIDTH-1:0] w_next [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_next[i] = r_regs[i];
        end
        case (r_mode)
            c_MODE_READ: begin
            end
            c_MODE_WRITE: begin
                // Port 2 is applied last so it wins when the selects alias.
                w_next[r_sel_a] = r_val1;
                w_next[r_sel_b] = r_val2;
            end
            c_MODE_SWAP: begin
                // Sourced from the current bank, so an aliased swap is a no-op.
                w_next[r_sel_a] = r_regs[r_sel_b];
                w_next[r_sel_b] = r_regs[r_sel_a];
            end
            c_MODE_CLEAR: begin
                for (int i = 0; i < NREGS; i++) begin
                    w_next[i] = '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over en and aborts any in-flight command.
            r_state <= c_IDLE;
            r_mode  <= c_MODE_READ;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_val1  <= '0;
            r_val2  <= '0;
            r_out1  <= '0;
            r_out2  <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_ready <= 1'b0;
                    if (en) begin
                        // Capture the whole command so inputs may change
                        // freely once it has been accepted.
                        r_mode  <= mode;
                        r_sel_a <= sel_a;
                        r_sel_b <= sel_b;
                        r_val1  <= value1;
                        r_val2  <= value2;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    for (int i = 0; i < NREGS; i++) begin
                        r_regs[i] <= w_next[i];
                    end
                    r_out1  <= w_next[r_sel_a];
                    r_out2  <= w_next[r_sel_b];
                    r_ready <= 1'b1;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    // en is deliberately not sampled here.
                    r_ready <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Output1 = r_out1;
    assign Output2 = r_out2;
    assign ready   = r_ready;
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_operand_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_bank
//  Purpose  : Self-checking bench for operand_bank. Two instances share one
//             command stream: an 8-bit/4-register bank (selects truncated to
//             2 bits, data to the low byte) and a 16-bit/8-register bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_bank;

    localparam logic [1:0] c_RD = 2'b00;
    localparam logic [1:0] c_WR = 2'b01;
    localparam logic [1:0] c_SW = 2'b10;
    localparam logic [1:0] c_CL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [15:0] value1;
    logic [15:0] value2;

    logic [7:0]  out1_n;
    logic [7:0]  out2_n;
    logic        ready_n;
    logic        busy_n;
    logic [15:0] out1_w;
    logic [15:0] out2_w;
    logic        ready_w;
    logic        busy_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_bank #(.WIDTH(8), .NREGS(4), .SEL_W(2)) u_narrow (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel_a   (sel_a[1:0]),
        .sel_b   (sel_b[1:0]),
        .value1  (value1[7:0]),
        .value2  (value2[7:0]),
        .Output1 (out1_n),
        .Output2 (out2_n),
        .ready   (ready_n),
        .busy    (busy_n)
    );

    operand_bank #(.WIDTH(16), .NREGS(8), .SEL_W(3)) u_wide (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .value1  (value1),
        .value2  (value2),
        .Output1 (out1_w),
        .Output2 (out2_w),
        .ready   (ready_w),
        .busy    (busy_w)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [7:0]  n1;
        logic [7:0]  n2;
        logic [15:0] w1;
        logic [15:0] w2;
        bit          hold;   // keep en high with junk through EXEC/DONE
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_both_flags(input string nm, input logic exp_ready, input logic exp_busy);
        chk({nm, " ready_n"}, {15'd0, ready_n}, {15'd0, exp_ready});
        chk({nm, " busy_n"},  {15'd0, busy_n},  {15'd0, exp_busy});
        chk({nm, " ready_w"}, {15'd0, ready_w}, {15'd0, exp_ready});
        chk({nm, " busy_w"},  {15'd0, busy_w},  {15'd0, exp_busy});
    endtask

    task automatic chk_outs(input string nm, input logic [7:0] n1, input logic [7:0] n2,
                            input logic [15:0] w1, input logic [15:0] w2);
        chk({nm, " out1_n"}, {8'd0, out1_n}, {8'd0, n1});
        chk({nm, " out2_n"}, {8'd0, out2_n}, {8'd0, n2});
        chk({nm, " out1_w"}, out1_w, w1);
        chk({nm, " out2_w"}, out2_w, w2);
    endtask

    // Accept edge, EXEC edge (ready high, outputs loaded), DONE edge (back
    // to IDLE, outputs held). With hold set, a CLEAR with random selects is
    // presented during EXEC/DONE and must be dropped.
    task automatic run_cmd(input string nm, input vec_t v);
        @(negedge clk);
        en     = 1'b1;
        mode   = v.mode;
        sel_a  = v.a;
        sel_b  = v.b;
        value1 = v.v1;
        value2 = v.v2;
        @(posedge clk); #1;
        chk_both_flags({nm, " accept"}, 1'b0, 1'b1);
        en     = v.hold;
        mode   = c_CL;
        sel_a  = 3'($urandom_range(0, 7));
        sel_b  = 3'($urandom_range(0, 7));
        value1 = 16'($urandom);
        value2 = 16'($urandom);
        @(posedge clk); #1;
        chk_both_flags({nm, " exec"}, 1'b1, 1'b1);
        chk_outs({nm, " exec"}, v.n1, v.n2, v.w1, v.w2);
        @(posedge clk); #1;
        chk_both_flags({nm, " done"}, 1'b0, 1'b0);
        chk_outs({nm, " hold"}, v.n1, v.n2, v.w1, v.w2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            mode  a     b     v1        v2        n1     n2     w1        w2        hold
        tbl[0]  = '{c_RD, 3'd0, 3'd3, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{c_WR, 3'd1, 3'd2, 16'h120A, 16'h340B, 8'h0A, 8'h0B, 16'h120A, 16'h340B, 1'b1};
        tbl[2]  = '{c_RD, 3'd1, 3'd2, 16'h0000, 16'h0000, 8'h0A, 8'h0B, 16'h120A, 16'h340B, 1'b1};
        tbl[3]  = '{c_WR, 3'd3, 3'd3, 16'h0011, 16'h0022, 8'h22, 8'h22, 16'h0022, 16'h0022, 1'b1};
        tbl[4]  = '{c_RD, 3'd3, 3'd3, 16'h0000, 16'h0000, 8'h22, 8'h22, 16'h0022, 16'h0022, 1'b1};
        tbl[5]  = '{c_SW, 3'd1, 3'd2, 16'h0000, 16'h0000, 8'h0B, 8'h0A, 16'h340B, 16'h120A, 1'b0};
        tbl[6]  = '{c_SW, 3'd2, 3'd2, 16'h0000, 16'h0000, 8'h0A, 8'h0A, 16'h120A, 16'h120A, 1'b0};
        tbl[7]  = '{c_RD, 3'd1, 3'd2, 16'h0000, 16'h0000, 8'h0B, 8'h0A, 16'h340B, 16'h120A, 1'b0};
        tbl[8]  = '{c_WR, 3'd5, 3'd6, 16'h1234, 16'hABCD, 8'h34, 8'hCD, 16'h1234, 16'hABCD, 1'b1};
        tbl[9]  = '{c_RD, 3'd1, 3'd5, 16'h0000, 16'h0000, 8'h34, 8'h34, 16'h340B, 16'h1234, 1'b0};
        tbl[10] = '{c_SW, 3'd7, 3'd3, 16'h0000, 16'h0000, 8'h22, 8'h22, 16'h0022, 16'h0000, 1'b0};
        tbl[11] = '{c_RD, 3'd3, 3'd7, 16'h0000, 16'h0000, 8'h22, 8'h22, 16'h0000, 16'h0022, 1'b0};
        tbl[12] = '{c_CL, 3'd1, 3'd2, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[13] = '{c_RD, 3'd6, 3'd1, 16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[14] = '{c_WR, 3'd0, 3'd4, 16'hFFFF, 16'h8001, 8'h01, 8'h01, 16'hFFFF, 16'h8001, 1'b0};
        tbl[15] = '{c_RD, 3'd4, 3'd0, 16'h0000, 16'h0000, 8'h01, 8'h01, 16'h8001, 16'hFFFF, 1'b0};

        // Reset with a WRITE strobed alongside it: the command must be lost.
        rst    = 1'b1;
        en     = 1'b1;
        mode   = c_WR;
        sel_a  = 3'd0;
        sel_b  = 3'd3;
        value1 = 16'hFFFF;
        value2 = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk_both_flags("reset", 1'b0, 1'b0);
        chk_outs("reset", 8'h00, 8'h00, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset lands on the EXEC edge of a WRITE: no update, no ready.
        @(negedge clk);
        en     = 1'b1;
        mode   = c_WR;
        sel_a  = 3'd0;
        sel_b  = 3'd0;
        value1 = 16'hFFFF;
        value2 = 16'hFFFF;
        @(posedge clk); #1;
        chk_both_flags("abort accept", 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk); #1;
        chk_both_flags("abort edge", 1'b0, 1'b0);
        chk_outs("abort edge", 8'h00, 8'h00, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_both_flags("abort after", 1'b0, 1'b0);
        run_cmd("abort read", '{c_RD, 3'd0, 3'd4, 16'h0, 16'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0});

        // Populate, then CLEAR and read back.
        run_cmd("pre clear wr", '{c_WR, 3'd2, 3'd7, 16'h00AA, 16'h5555, 8'hAA, 8'h55, 16'h00AA, 16'h5555, 1'b0});
        run_cmd("clear",        '{c_CL, 3'd2, 3'd7, 16'h1111, 16'h2222, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0});
        run_cmd("post clear rd",'{c_RD, 3'd2, 3'd7, 16'h0, 16'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
